// File: rtl/sipo_framer_if.sv
// Handshake bundle between a beat producer, the framer and a word consumer.
// The slave modport is the framer's own view of the bundle.
interface sipo_framer_if #(
    parameter int SIZE_DATA_IN  = 1,
    parameter int SIZE_DATA_OUT = 8
);
    localparam int DEPTH    = SIZE_DATA_OUT / SIZE_DATA_IN;
    localparam int SIZE_CNT = $clog2(DEPTH + 1);

    logic                     i_valid;
    logic [SIZE_DATA_IN-1:0]  i_data;
    logic                     i_flush;
    logic                     o_ready;
    logic                     o_valid;
    logic [SIZE_DATA_OUT-1:0] o_data;
    logic [SIZE_CNT-1:0]      o_count;
    logic                     o_last;
    logic                     i_ready;

    modport master (
        output i_valid, i_data, i_flush, i_ready,
        input  o_ready, o_valid, o_data, o_count, o_last
    );

    modport slave (
        input  i_valid, i_data, i_flush, i_ready,
        output o_ready, o_valid, o_data, o_count, o_last
    );
endinterface

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: packs SIZE_DATA_IN-bit beats into SIZE_DATA_OUT-bit
// words with valid/ready on both sides, selectable bit order, and a flush that
// emits a zero-padded partial word tagged with o_last.
module sipo_framer #(
    parameter int SIZE_DATA_IN  = 1,
    parameter int SIZE_DATA_OUT = 8,
    parameter bit MSB_FIRST     = 1'b1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    sipo_framer_if.slave  bus
);
    localparam int DEPTH    = SIZE_DATA_OUT / SIZE_DATA_IN;
    localparam int SIZE_CNT = $clog2(DEPTH + 1);
    localparam logic [SIZE_CNT-1:0] LAST_IDX = SIZE_CNT'(DEPTH - 1);

    logic [SIZE_CNT-1:0]      cnt_q;
    logic [SIZE_DATA_OUT-1:0] acc_q;
    logic [SIZE_DATA_OUT-1:0] acc_next;
    logic [SIZE_CNT-1:0]      total;
    logic                     valid_q;
    logic                     last_q;
    logic [SIZE_DATA_OUT-1:0] data_q;
    logic [SIZE_CNT-1:0]      count_q;
    logic                     slot_free;
    logic                     last_beat;
    logic                     rdy;
    logic                     beat_acc;
    logic                     flush_acc;
    logic                     emit;

    // Handshake decode and next accumulator image with the incoming beat merged in.
    // o_ready only drops when a completing event would need an occupied output slot.
    always_comb begin
        slot_free = !valid_q | bus.i_ready;
        last_beat = bus.i_valid & (cnt_q == LAST_IDX);
        rdy       = slot_free | !(last_beat | bus.i_flush);
        beat_acc  = bus.i_valid & rdy;
        flush_acc = bus.i_flush & rdy;
        total     = cnt_q + {{(SIZE_CNT-1){1'b0}}, beat_acc};
        emit      = (beat_acc & (cnt_q == LAST_IDX)) |
                    (flush_acc & (total != '0));
        acc_next  = acc_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (beat_acc && (cnt_q == SIZE_CNT'(k))) begin
                if (MSB_FIRST)
                    acc_next[SIZE_DATA_OUT-1-k*SIZE_DATA_IN -: SIZE_DATA_IN] = bus.i_data;
                else
                    acc_next[k*SIZE_DATA_IN +: SIZE_DATA_IN] = bus.i_data;
            end
        end
    end

    // Beat counter and accumulator; both clear whenever a word is handed to the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (emit) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (beat_acc) begin
            cnt_q <= total;
            acc_q <= acc_next;
        end
    end

    // Output word register; holds while the consumer stalls, reloads back-to-back otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else if (emit) begin
            valid_q <= 1'b1;
            data_q  <= acc_next;
            count_q <= total;
            last_q  <= flush_acc;
        end else if (bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_ready = rdy;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_count = count_q;
    assign bus.o_last  = last_q;
endmodule

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
Parametrised serial-to-parallel converter for the Viterbi decoder datapath. Packs SIZE_DATA_IN-bit beats into SIZE_DATA_OUT-bit words.
Adds three things over the existing SIPO: valid/ready handshakes on both sides, selectable bit order, and a flush that emits a zero-padded partial word.
Sits between the bit-serial traceback/decision stream and word-oriented consumers such as the output buffer and CRC.

Parameters:
SIZE_DATA_IN, 1, beat width in bits.
SIZE_DATA_OUT, 8, output word width; must be an integer multiple of SIZE_DATA_IN.
MSB_FIRST, 1, 1 = first beat lands in the top slice of o_data; 0 = first beat lands in bits [SIZE_DATA_IN-1:0].
Derived: DEPTH = SIZE_DATA_OUT/SIZE_DATA_IN (must be >= 2); SIZE_CNT = $clog2(DEPTH+1).

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  beat valid
i_data  input  SIZE_DATA_IN  beat data
i_flush  input  1  request to close the current frame; held until accepted
o_ready  output  1  upstream may transfer a beat/flush this cycle
o_valid  output  1  output word valid
o_data  output  SIZE_DATA_OUT  packed word
o_count  output  SIZE_CNT  number of valid beats in o_data (1..DEPTH)
o_last  output  1  word was produced by a flush
i_ready  input  1  downstream accepts the word

Behaviour:
- Reset (async assert, sync deassert assumed upstream): beat counter cnt=0, accumulator=0, o_valid=0, o_data=0, o_count=0, o_last=0. Reset mid-frame discards partial data and any pending output word.
- Output slot free this cycle: slot_free = !o_valid | i_ready.
- Completing event: (i_valid & cnt==DEPTH-1) | i_flush.
- o_ready = slot_free | !completing event. This is combinational from i_ready, i_valid and i_flush; no internal loop.
- Beat accepted when i_valid & o_ready. It is written to slot index cnt and cnt increments.
- Slot position for index k:
  - MSB_FIRST=1: bits [SIZE_DATA_OUT-1-k*SIZE_DATA_IN -: SIZE_DATA_IN].
  - MSB_FIRST=0: bits [k*SIZE_DATA_IN +: SIZE_DATA_IN].
- Full word: the beat accepted at cnt==DEPTH-1 completes the word. On that edge:
  - the assembled word (including this beat) loads o_data;
  - o_valid=1, o_count=DEPTH, o_last=0 (unless i_flush is also high, which sets o_last=1);
  - cnt returns to 0 and the accumulator clears to 0.
- Latency: o_valid rises the cycle after the final beat is accepted. Sustained throughput is one beat per cycle with no bubble between words while i_ready=1.
- Flush is accepted when i_flush & o_ready.
  - Same-cycle i_valid: the beat is included first, then the frame closes.
  - If the resulting beat total is >0: emit the partial word with unfilled slots = 0, o_count = beats held, o_last=1; cnt and accumulator clear.
  - If the total is 0 (cnt==0, no beat): flush is accepted with no output and no state change.
- Output hold: while o_valid & !i_ready, o_data, o_count and o_last are stable. Accumulation continues until a completing event stalls on o_ready.
- Output handoff: o_valid drops the cycle after i_ready, unless a new word loads on the same edge (back-to-back).
- o_data keeps its last value when o_valid=0; consumers must qualify with o_valid.
- When i_valid=0, i_data is ignored.

Test Plan:
- Default params, i_ready=1, beats 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th beat: o_valid=1, o_data=8'hB2, o_count=8, o_last=0; o_ready stays 1 throughout.
- MSB_FIRST=0, same beats -> o_data=8'h4D, o_count=8.
- 16 beats back-to-back (0xB2 then 0x0F MSB-first), i_ready=1 -> two words on cycles 9 and 17; no o_ready deassertion.
- Word 0xB2 pending, i_ready=0, 8 more beats offered -> first 7 accepted; o_ready=0 on the 8th; o_data held at 0xB2. Raise i_ready -> 0xB2 consumed, 8th beat accepted on the same edge, next word valid the following cycle.
- Beats 1,1,0 then i_flush=1 with no beat -> o_data=8'hC0, o_count=3, o_last=1. A flush with cnt=0 produces no o_valid.
- i_rst_n pulsed low after 5 beats, then 8 beats 0xFF -> o_data=8'hFF, o_count=8 with no earlier bits leaked in. SIZE_DATA_IN=2: beats 2'b10,2'b11,2'b00,2'b01 -> o_data=8'hB1.
